// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction class encodings, class field position,
// and the sequencer state encoding.
package cpu_pkg;

  localparam int DEF_INSTR_WIDTH = 20;
  localparam int CLS_HI          = 19;
  localparam int CLS_LO          = 18;

  typedef enum logic [1:0] {
    CLS_HALT = 2'b00,
    CLS_STD  = 2'b01,
    CLS_LDR  = 2'b10,
    CLS_STR  = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_HALT      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/issue_timer.sv
// Hold-time down-counter: loads (class cycle count - 1), decrements while
// enabled, and flags the final hold cycle with done_o.
module issue_timer import cpu_pkg::*; #(
  parameter int STD_CYCLES = 3,
  parameter int LDR_CYCLES = 4,
  parameter int STR_CYCLES = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [1:0] cls_i,
  input  logic       en_i,
  output logic       done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d, load_val;

  always_comb begin
    load_val = '0;
    case (cls_e'(cls_i))
      CLS_STD: load_val = CNT_W'(STD_CYCLES - 1);
      CLS_LDR: load_val = CNT_W'(LDR_CYCLES - 1);
      CLS_STR: load_val = CNT_W'(STR_CYCLES - 1);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val;
    else if (en_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches instructions over a req/valid handshake and
// presents each to the control unit for its class-specific cycle count.
module instr_sequencer import cpu_pkg::*; #(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_BITS     = 5,
  parameter int STD_CYCLES  = 3,
  parameter int LDR_CYCLES  = 4,
  parameter int STR_CYCLES  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step,
  output logic                   imem_rd,
  output logic [PC_BITS-1:0]     imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   imem_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   issue,
  output logic [PC_BITS-1:0]     pc,
  output logic                   busy,
  output logic                   halted,
  output logic [7:0]             instr_count
);

  seq_state_e             state_q, state_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   issue_q, issue_d;
  logic                   load, hold_done;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    issue_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          // A halt word is not latched so the control unit keeps the last op
          if (cls_e'(imem_data[CLS_HI:CLS_LO]) == CLS_HALT) begin
            state_d = S_HALT;
          end else begin
            instr_d = imem_data;
            issue_d = 1'b1;
            load    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (hold_done) begin
          pc_d    = pc_q + PC_BITS'(1);
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d = step_mode ? S_STEP_WAIT : S_FETCH;
        end
      end
      S_STEP_WAIT: if (step || !step_mode) state_d = S_FETCH;
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      issue_q <= issue_d;
    end
  end

  issue_timer #(
    .STD_CYCLES(STD_CYCLES),
    .LDR_CYCLES(LDR_CYCLES),
    .STR_CYCLES(STR_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(load),
    .cls_i (imem_data[CLS_HI:CLS_LO]),
    .en_i  (state_q == S_ISSUE),
    .done_o(hold_done)
  );

  assign imem_rd     = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign issue       = issue_q;
  assign instr_count = cnt_q;
  assign halted      = (state_q == S_HALT);
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                       (state_q == S_STEP_WAIT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer with a responding instruction memory
// and a program-level reference model (pc, retire count, class hold lengths).
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, step_mode, step;
  logic        imem_rd, imem_valid, issue, busy, halted;
  logic [4:0]  imem_addr, pc;
  logic [19:0] imem_data, instr;
  logic [7:0]  instr_count;

  int checks = 0;
  int errors = 0;

  logic [19:0] mem [32];
  int          lat = 1;
  int          rcnt = 0;
  logic        rsp_valid = 1'b0, inj_valid = 1'b0;
  logic [19:0] rsp_data = '0, inj_data = '0;

  int          m_pc, m_cnt;
  logic [19:0] m_instr;

  assign imem_valid = rsp_valid | inj_valid;
  assign imem_data  = inj_valid ? inj_data : rsp_data;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_valid(imem_valid), .instr(instr), .issue(issue), .pc(pc),
    .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Memory answers in the lat-th cycle of an outstanding request
  always @(negedge clk) begin
    if (imem_rd !== 1'b1) begin
      rcnt = 0;
      rsp_valid = 1'b0;
    end else begin
      rcnt++;
      rsp_valid = (rcnt == lat);
      rsp_data  = mem[imem_addr];
    end
  end

  function automatic int hold_of(logic [19:0] w);
    case (w[19:18])
      2'b01:   return 3;
      2'b10:   return 4;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_mode = 1'b0;
    tick();
    rst = 1'b0;
    m_pc = 0; m_cnt = 0; m_instr = '0;
    tick();
  endtask

  // Called on the first FETCH cycle; runs one instruction through retire.
  task automatic exec_one(input bit inject, output bit hit_halt);
    int t, h;
    bit bad;
    logic [19:0] w;
    hit_halt = 1'b0;
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== m_pc[4:0]) begin
      errors++;
      $display("FAIL fetch_addr rd=%b addr=%0d expected rd=1 addr=%0d", imem_rd, imem_addr, m_pc);
    end
    t = 0;
    do begin tick(); t++; end while (!(issue === 1'b1 || halted === 1'b1) && t < 20);
    checks++;
    if (t >= 20) begin
      errors++;
      $display("FAIL fetch_timeout no issue/halt after %0d cycles at pc=%0d", t, m_pc);
      hit_halt = 1'b1;
      return;
    end
    if (t != lat) begin
      errors++;
      $display("FAIL fetch_latency got %0d expected %0d", t, lat);
    end
    w = mem[m_pc];
    if (w[19:18] == 2'b00) begin
      hit_halt = 1'b1;
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || pc !== m_pc[4:0] || instr !== m_instr ||
          instr_count !== m_cnt[7:0]) begin
        errors++;
        $display("FAIL halt_state halted=%b busy=%b pc=%0d instr=%h cnt=%0d expected 1 0 %0d %h %0d",
                 halted, busy, pc, instr, instr_count, m_pc, m_instr, m_cnt);
      end
      return;
    end
    m_instr = w;
    checks++;
    if (instr !== w) begin
      errors++;
      $display("FAIL issue_instr got %h expected %h", instr, w);
    end
    h = 0;
    bad = 1'b0;
    do begin
      if (inject && h == 1) begin
        start = 1'b1;
        inj_valid = 1'b1;
        inj_data = w ^ 20'h5_5555;
      end
      tick();
      start = 1'b0;
      inj_valid = 1'b0;
      h++;
      if (instr !== w || issue !== 1'b0) bad = 1'b1;
    end while (imem_rd !== 1'b1 && h < 20);
    checks++;
    if (h != hold_of(w)) begin
      errors++;
      $display("FAIL hold_len got %0d expected %0d instr=%h", h, hold_of(w), w);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL instr_stable instr=%h issue=%b expected %h 0", instr, issue, w);
    end
    m_pc = (m_pc + 1) % 32;
    if (m_cnt < 255) m_cnt++;
    checks++;
    if (pc !== m_pc[4:0] || instr_count !== m_cnt[7:0]) begin
      errors++;
      $display("FAIL retire pc=%0d cnt=%0d expected %0d %0d", pc, instr_count, m_pc, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    repeat (2) tick();
    checks++;
    if ({imem_rd, imem_addr, instr, issue, pc, busy, halted, instr_count} !== '0) begin
      errors++;
      $display("FAIL reset_state rd=%b addr=%0d instr=%h issue=%b pc=%0d busy=%b halted=%b cnt=%0d expected all 0",
               imem_rd, imem_addr, instr, issue, pc, busy, halted, instr_count);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || imem_rd !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold busy=%b rd=%b expected 0 0", busy, imem_rd);
    end
    m_pc = 0; m_cnt = 0; m_instr = '0;
  endtask

  task automatic test_basic();
    bit hh;
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 20'h4_1230;
    lat = 1;
    do_start();
    exec_one(1'b0, hh);
    exec_one(1'b0, hh);
    checks++;
    if (!hh) begin
      errors++;
      $display("FAIL basic_halt halted=%b expected 1", halted);
    end
  endtask

  task automatic test_program();
    bit hh;
    int n;
    foreach (mem[i]) mem[i] = '0;
    mem[0] = {2'b01, 18'($urandom)};
    mem[1] = {2'b10, 18'($urandom)};
    mem[2] = {2'b11, 18'($urandom)};
    lat = 2;
    do_start();
    m_pc = 0; m_cnt = 0;
    n = 0;
    do begin exec_one(1'b0, hh); n++; end while (!hh && n < 6);
    checks++;
    if (halted !== 1'b1 || pc !== 5'd3 || instr_count !== 8'd3) begin
      errors++;
      $display("FAIL program_end halted=%b pc=%0d cnt=%0d expected 1 3 3", halted, pc, instr_count);
    end
    do_start();
    checks++;
    if (pc !== 5'd0 || instr_count !== 8'd0 || halted !== 1'b0 || imem_rd !== 1'b1 ||
        imem_addr !== 5'd0) begin
      errors++;
      $display("FAIL restart pc=%0d cnt=%0d halted=%b rd=%b addr=%0d expected 0 0 0 1 0",
               pc, instr_count, halted, imem_rd, imem_addr);
    end
    do_reset();
  endtask

  task automatic test_step();
    bit hh, stuck;
    int t;
    foreach (mem[i]) mem[i] = '0;
    mem[0] = {2'b10, 18'($urandom)};
    mem[1] = {2'b10, 18'($urandom)};
    lat = 1;
    step_mode = 1'b1;
    do_start();
    t = 0;
    do begin tick(); t++; end while (issue !== 1'b1 && t < 20);
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1 || imem_rd !== 1'b0 || pc !== 5'd1 || instr_count !== 8'd1 ||
        instr !== mem[0]) begin
      errors++;
      $display("FAIL step_wait busy=%b rd=%b pc=%0d cnt=%0d instr=%h expected 1 0 1 1 %h",
               busy, imem_rd, pc, instr_count, instr, mem[0]);
    end
    stuck = 1'b0;
    repeat (4) begin tick(); if (imem_rd !== 1'b0) stuck = 1'b1; end
    checks++;
    if (stuck) begin
      errors++;
      $display("FAIL step_hold rd went 1 expected 0 without step");
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    step_mode = 1'b0;
    m_pc = 1; m_cnt = 1; m_instr = mem[0];
    exec_one(1'b0, hh);
    exec_one(1'b0, hh);
    checks++;
    if (!hh) begin
      errors++;
      $display("FAIL step_halt halted=%b expected 1", halted);
    end
    do_reset();
  endtask

  task automatic test_wrap_saturate();
    bit hh;
    foreach (mem[i]) mem[i] = {2'($urandom_range(1, 3)), 18'($urandom)};
    lat = $urandom_range(1, 3);
    do_start();
    for (int k = 0; k < 300; k++) begin
      exec_one($urandom_range(0, 7) == 0, hh);
      if (hh) break;
    end
    checks++;
    if (instr_count !== 8'd255 || pc !== 5'(300 % 32) || hh) begin
      errors++;
      $display("FAIL saturate cnt=%0d pc=%0d expected 255 %0d", instr_count, pc, 300 % 32);
    end
    do_reset();
  endtask

  task automatic test_rst_mid();
    int t;
    foreach (mem[i]) mem[i] = '0;
    mem[0] = {2'b10, 18'($urandom)};
    lat = 1;
    do_start();
    t = 0;
    do begin tick(); t++; end while (issue !== 1'b1 && t < 20);
    tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({imem_rd, imem_addr, instr, issue, pc, busy, halted, instr_count} !== '0) begin
      errors++;
      $display("FAIL async_reset rd=%b instr=%h issue=%b pc=%0d busy=%b halted=%b cnt=%0d expected all 0",
               imem_rd, instr, issue, pc, busy, halted, instr_count);
    end
    tick();
    rst = 1'b0;
    tick();
    do_start();
    checks++;
    if (imem_rd !== 1'b1 || imem_addr !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_fetch rd=%b addr=%0d expected 1 0", imem_rd, imem_addr);
    end
    do_reset();
  endtask

  task automatic test_ignored_inputs();
    bit hh;
    foreach (mem[i]) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem[i] = {2'($urandom_range(1, 3)), 18'($urandom)};
    lat = 2;
    do_start();
    for (int i = 0; i < 5; i++) exec_one(1'b1, hh);
    checks++;
    if (!hh) begin
      errors++;
      $display("FAIL inject_halt halted=%b expected 1", halted);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_program();
    test_step();
    test_rst_mid();
    test_ignored_inputs();
    do_reset();
    test_wrap_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer for the multi-cycle CPU.
- Owns the program counter and fetches 20-bit instructions from an instruction memory over a req/valid handshake.
- Drives the control unit's instruction input, holding each instruction stable for exactly the cycle count of its class (std_op / loadR / storeR).
- Provides run, halt and single-step control for bring-up and the bench.

Parameters:
INSTR_WIDTH, 20, instruction width; class field is bits [19:18]
PC_BITS, 5, program counter width (32 instruction slots)
STD_CYCLES, 3, hold cycles for class 01 (std_op)
LDR_CYCLES, 4, hold cycles for class 10 (loadR)
STR_CYCLES, 3, hold cycles for class 11 (storeR)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  reset; asynchronous, active-high
start  in  1  one-cycle pulse; begins execution from IDLE or HALT
step_mode  in  1  1 = pause after every instruction
step  in  1  one-cycle pulse; releases one instruction in step mode
imem_rd  out  1  fetch request to instruction memory
imem_addr  out  PC_BITS  fetch address; equals pc
imem_data  in  INSTR_WIDTH  fetched instruction; valid when imem_valid=1
imem_valid  in  1  fetch completion strobe
instr  out  INSTR_WIDTH  instruction presented to the control unit
issue  out  1  high on the first cycle a new instr is presented
pc  out  PC_BITS  current program counter
busy  out  1  high in FETCH, ISSUE and STEP_WAIT
halted  out  1  high in HALT
instr_count  out  8  retired instruction count, saturating at 255

Behaviour:
- Reset (asynchronous, effective immediately, including mid-fetch or mid-issue):
  - state=IDLE; pc=0, instr=0, imem_rd=0, issue=0, busy=0, halted=0, instr_count=0.
  - imem_addr = pc = 0.
- States: IDLE, FETCH, ISSUE, STEP_WAIT, HALT.
- IDLE:
  - start=1 -> FETCH next cycle.
  - Otherwise stay.
- FETCH:
  - imem_rd=1 and imem_addr=pc, both held stable until imem_valid is sampled high.
  - Minimum latency is 1 cycle; a same-cycle imem_valid is not permitted, so imem_valid in the first FETCH cycle counts as 1-cycle latency.
  - On imem_valid, imem_data[19:18]==00 -> HALT. instr is unchanged and pc is not incremented.
  - On imem_valid, any other class:
    - instr <= imem_data;
    - issue=1 for the next cycle only;
    - hold counter loaded with N-1, where N is the class cycle count;
    - -> ISSUE.
  - imem_rd drops in the cycle after imem_valid.
- ISSUE:
  - instr held constant for exactly N cycles; the counter decrements each cycle.
  - On the final cycle (counter==0):
    - pc <= pc+1, wrapping modulo 2^PC_BITS (31 -> 0);
    - instr_count <= instr_count+1, saturating at 255;
    - step_mode=1 -> STEP_WAIT, else -> FETCH.
- STEP_WAIT:
  - instr retains its last value.
  - step=1 or step_mode=0 -> FETCH.
- HALT:
  - halted=1, busy=0, instr retains its last value.
  - start=1 -> pc<=0, instr_count<=0, halted<=0 -> FETCH.
- start while busy: ignored.
- step outside STEP_WAIT: ignored.
- step_mode change during ISSUE takes effect at that instruction's final cycle.
- imem_valid outside FETCH: ignored.
- instr is never modified except on a successful non-halt fetch, so the control unit never sees a mid-instruction change.
- Between instructions, instr keeps its prior value; the control unit's phase alignment relies on the issue strobe and the fixed class durations.

Decomposition:
- Shared package cpu_pkg:
  - class encodings CLS_HALT=2'b00, CLS_STD=2'b01, CLS_LDR=2'b10, CLS_STR=2'b11;
  - class field bit positions [19:18];
  - state encoding constants for this block;
  - INSTR_WIDTH default.
- One sub-module, issue_timer:
  - loadable down-counter with a load value selected from class via the three cycle parameters;
  - done output when the count reaches 0.
- The FSM, pc and instr_count stay in instr_sequencer.

Test Plan:
- Reset then start; imem returns 20'h4_1230 (class 01) with 1-cycle latency -> issue pulses once, instr=20'h41230 for exactly 3 cycles, pc 0->1, instr_count=1.
- Program of 01, 10, 11 instructions, then 20'h00000 at address 3, memory latency 2 cycles:
  - holds of 3/4/3 cycles respectively;
  - halted=1, pc=3, instr_count=3;
  - start restarts with pc=0, instr_count=0.
- step_mode=1, two class-10 instructions -> after first retire, STEP_WAIT with busy=1 and imem_rd=0; no fetch until step pulse; step pulse -> imem_rd=1 next cycle, addr=1.
- Start at pc=31 via a full 32-instruction non-halt program -> pc wraps 31->0, fetch addr=0; after 300 instructions instr_count saturates at 255.
- Assert rst during the 2nd cycle of a loadR hold -> all outputs 0 in the same cycle without a clock edge; start afterwards fetches addr 0.
- start pulsed during ISSUE, and imem_valid pulsed during ISSUE -> no effect: hold length, pc and instr unchanged.
